// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_responder: single-outstanding load/store responder with a       |
// | byte-enabled word array and programmable response latency.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_offset;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_accept;

  // Range check uses the full 32-bit offset so addresses below BASE_ADDR
  // (which wrap to huge offsets) are rejected rather than aliased.
  assign w_offset = req_addr - BASE_ADDR;
  assign w_err    = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                    ((w_offset >> 2) >= 32'(DEPTH_WORDS));
  assign w_idx    = w_offset[AW+1:2];
  assign w_accept = req_valid && req_ready;

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Every request passes through WAIT (even with zero extra cycles) so the
  // response always appears 1+WAIT_CYCLES cycles after acceptance.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= c_WAIT_LOAD;
        r_err   <= w_err;
        r_rdata <= (w_err || req_we) ? 32'd0 : r_mem[w_idx];
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Storage is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (rst && w_accept && req_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_responder: scoreboard bench for data_mem_responder.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Drive one request (caller sits just after a rising edge); returns after
  // the acceptance edge and pushes the model's expected response.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int waits);
    bit   acc;
    exp_t e;
    int   idx;
    acc   = 1'b0;
    waits = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    while (!acc && waits < 20) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept: addr %h not accepted, waited %0d cycles (limit 20)", addr, waits);
    end else begin
      e.rdata = 32'd0;
      e.err   = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
      if (!e.err) begin
        idx = int'(addr >> 2);
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          e.rdata = model[idx];
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic collect(input int exp_lat, input int hold, input string name);
    int          k;
    bit          seen;
    exp_t        e;
    logic [31:0] held;
    k = 0; seen = 1'b0;
    while (!seen && k < 30) begin
      @(posedge clk); #1;
      k++;
      seen = rsp_valid;
    end
    n_checks++;
    if (!seen || k != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (valid=%0b), expected %0d", name, k, seen, exp_lat);
    end
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s scoreboard: no expected entry, got rdata=%h err=%0b", name, rsp_rdata, rsp_err);
      rsp_ready = 1'b1;
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      n_fail++;
      $display("FAIL %s data: got rdata=%h err=%0b, expected rdata=%h err=%0b",
               name, rsp_rdata, rsp_err, e.rdata, e.err);
    end
    held = rsp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold: got valid=%0b rdata=%h ready=%0b, expected 1 %h 0",
                 name, rsp_valid, rsp_rdata, req_ready, held);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: got valid=%0b ready=%0b, expected 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got valid=%0b rdata=%h err=%0b, expected 0 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset release: got ready=%0b valid=%0b z_ready=%0b, expected 1 0 1",
               req_ready, rsp_valid, z_req_ready);
    end
  endtask

  task automatic test_store_load();
    int w;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w);      collect(2, 0, "store10");
    issue(1'b0, 32'h10, 32'h0, 4'h0, w);             collect(2, 0, "load10");
    issue(1'b1, 32'h0, 32'h01020304, 4'hF, w);       collect(2, 0, "store0");
    issue(1'b1, 32'(4*DEPTH-4), 32'h55AA55AA, 4'hF, w); collect(2, 0, "store_last");
    issue(1'b0, 32'(4*DEPTH-4), 32'h0, 4'hF, w);     collect(2, 0, "load_last");
  endtask

  task automatic test_partial();
    int w;
    issue(1'b1, 32'h10, 32'h11223344, 4'b0101, w);   collect(2, 0, "partial_store");
    issue(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, w);      collect(2, 0, "partial_load");
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, w);   collect(2, 0, "be0_store");
    issue(1'b0, 32'h10, 32'h0, 4'h0, w);             collect(2, 0, "be0_load");
  endtask

  task automatic test_errors();
    int w;
    issue(1'b0, 32'h13, 32'h0, 4'hF, w);             collect(2, 0, "misaligned_load");
    issue(1'b1, 32'(4*DEPTH), 32'hCAFEF00D, 4'hF, w); collect(2, 0, "oor_store");
    issue(1'b1, 32'h12, 32'h0, 4'hF, w);             collect(2, 0, "misaligned_store");
    issue(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, w);       collect(2, 0, "far_load");
    issue(1'b0, 32'h10, 32'h0, 4'h0, w);             collect(2, 0, "after_err_10");
    issue(1'b0, 32'h0, 32'h0, 4'h0, w);              collect(2, 0, "after_err_0");
  endtask

  task automatic test_backpressure();
    int w;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, w);
    collect(2, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    int w;
    issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF, w);      collect(2, 0, "b2b_store");
    issue(1'b0, 32'h20, 32'h0, 4'h0, w);
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d wait cycles, expected 0", w);
    end
    collect(2, 0, "b2b_load");
  endtask

  task automatic test_wait0();
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h20;
    z_req_wdata = 32'hA5A55A5A; z_req_be = 4'hF;
    n_checks++;
    if (z_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL w0_ready: got %0b, expected 1", z_req_ready);
    end
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_wdata = 32'h0;
    n_checks++;
    if (z_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_early: got valid=%0b right after acceptance, expected 0", z_rsp_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'd0 || z_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_store_rsp: got valid=%0b rdata=%h err=%0b, expected 1 0 0",
               z_rsp_valid, z_rsp_rdata, z_rsp_err);
    end
    @(posedge clk); #1;
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h20;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_addr = 32'h0;
    @(posedge clk); #1;
    n_checks++;
    if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'hA5A55A5A || z_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_load_rsp: got valid=%0b rdata=%h err=%0b, expected 1 a5a55a5a 0",
               z_rsp_valid, z_rsp_rdata, z_rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int w;
    bit bad;
    issue(1'b0, 32'h10, 32'h0, 4'h0, w);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%0b during reset, expected 0", rsp_valid);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_drop: got stray valid=%0b ready=%0b, expected 0 1", bad, req_ready);
    end
    issue(1'b0, 32'h10, 32'h0, 4'h0, w);             collect(2, 0, "retained_10");
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_req_be = 4'h0;
    z_rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    test_reset();
    test_store_load();
    test_partial();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_wait0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
